// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider: one trial subtraction per clock through a ripple-carry subtractor.
// Optional signed mode is enabled by defining SIGNED_DIV_EN (adds a FIXUP state).
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;
`ifdef SIGNED_DIV_EN
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
`endif

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Trial subtraction T - D as T + ~{0,D} + 1; carry-out high means no borrow.
    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   b_val;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;
    logic             unused_r_msb;

    assign t_val        = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign b_val        = ~{1'b0, d_reg};
    assign carry[0]     = 1'b1;
    assign no_borrow    = carry[WIDTH+1];
    assign unused_r_msb = r_reg[WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_rca
            assign diff[gi]    = t_val[gi] ^ b_val[gi] ^ carry[gi];
            assign carry[gi+1] = (t_val[gi] & b_val[gi]) | (carry[gi] & (t_val[gi] ^ b_val[gi]));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        r_next         = r_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
`ifdef SIGNED_DIV_EN
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef SIGNED_DIV_EN
                    d_next     = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
                    q_next     = dividend[WIDTH-1] ? negate(dividend) : dividend;
                    neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_r_next = dividend[WIDTH-1];
`else
                    d_next     = divisor;
                    q_next     = dividend;
`endif
                    r_next     = '0;
                    cnt_next   = '0;
                    dbz_next   = 1'b0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (d_reg == '0) begin
                    // Q still holds the captured dividend (or its magnitude).
                    quotient_next = '1;
`ifdef SIGNED_DIV_EN
                    remainder_next = neg_r_reg ? negate(q_reg) : q_reg;
`else
                    remainder_next = q_reg;
`endif
                    dbz_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    if (no_borrow) begin
                        r_next = diff;
                        q_next = {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_next = t_val;
                        q_next = {q_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                        state_next     = S_FIXUP;
`else
                        quotient_next  = q_next;
                        remainder_next = r_next[WIDTH-1:0];
                        state_next     = S_DONE;
`endif
                    end
                end
            end
`ifdef SIGNED_DIV_EN
            S_FIXUP: begin
                quotient_next  = neg_q_reg ? negate(q_reg) : q_reg;
                remainder_next = neg_r_reg ? negate(r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
                state_next     = S_DONE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            r_reg         <= r_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
`ifdef SIGNED_DIV_EN
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
`endif
        end
    end

    assign busy        = (state_reg == S_RUN) || (state_reg == S_FIXUP);
    assign done        = (state_reg == S_DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: vector table, reset/handshake sequences, random identity checks.
module tb_seq_divider32;

`ifdef SIGNED_DIV_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks;
    int failures;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; counts rising edges until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat, output logic busy0);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        wait_done(lat);
    endtask

    initial begin
        int          lat;
        int          n;
        logic        busy0;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] recon;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{32'd100,     32'd7,    32'd14,         32'd2,         1'b0};
        vecs[1] = '{32'd5,       32'd9,    32'd0,          32'd5,         1'b0};
        vecs[2] = '{32'h1234,    32'd0,    32'hFFFFFFFF,   32'h1234,      1'b1};
        vecs[3] = '{32'hFFFFFF00,32'd0,    32'hFFFFFFFF,   32'hFFFFFF00,  1'b1};
        vecs[4] = '{32'd0,       32'd5,    32'd0,          32'd0,         1'b0};
        vecs[5] = '{32'd1000000, 32'd1000, 32'd1000,       32'd0,         1'b0};
`ifdef SIGNED_DIV_EN
        vecs[6] = '{32'hFFFFFFF9,32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[7] = '{32'd7,       32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[8] = '{32'h80000000,32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[9] = '{32'hFFFFFF9C,32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
`else
        vecs[6] = '{32'hFFFFFFFF,32'h10,       32'h0FFFFFFF, 32'hF,        1'b0};
        vecs[7] = '{32'hFFFFFFFF,32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[8] = '{32'h80000000,32'd3,        32'h2AAAAAAA, 32'd2,        1'b0};
        vecs[9] = '{32'd12345678,32'd1,        32'd12345678, 32'd0,        1'b0};
`endif

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, busy0);
            $display("vec %0d: %h / %h -> q=%h r=%h dbz=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, quotient, remainder, div_by_zero, lat);
            chk($sformatf("vec%0d_busy", i), {31'd0, busy0}, 32'd1);
            chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].dbz ? 32'd1 : LAT);
        end

        // Asynchronous reset in the middle of a RUN, after a divide-by-zero left nonzero outputs.
        do_op(32'h55, 32'd0, lat, busy0);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("mid-run reset: busy=%0b done=%0b q=%h r=%h dbz=%0b", busy, done, quotient, remainder, div_by_zero);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd100, 32'd7, lat, busy0);
        $display("after reset: 100/7 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        chk("postrst_quotient", quotient, 32'd14);
        chk("postrst_remainder", remainder, 32'd2);
        chk("postrst_latency", lat, LAT);

        // start pulsed during RUN must be ignored; outputs hold the previous result meanwhile.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 10) begin
                chk("ignore_stable_quotient", quotient, 32'd14);
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        $display("ignored start: 1000/3 -> q=%0d r=%0d lat=%0d", quotient, remainder, n);
        chk("ignore_quotient", quotient, 32'd333);
        chk("ignore_remainder", remainder, 32'd1);
        chk("ignore_latency", n, LAT);

        // start held high: back-to-back operations.
        @(negedge clk);
        dividend = 32'd200;
        divisor  = 32'd9;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd4;
        wait_done(lat);
        $display("b2b first: 200/9 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        chk("b2b1_quotient", quotient, 32'd22);
        chk("b2b1_remainder", remainder, 32'd2);
        chk("b2b1_latency", lat, LAT);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_reaccept_done", {31'd0, done}, 32'd0);
        chk("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
        chk("b2b_hold_quotient", quotient, 32'd22);
        chk("b2b_hold_remainder", remainder, 32'd2);
        wait_done(n);
        start = 1'b0;
        $display("b2b second: 77/4 -> q=%0d r=%0d period=%0d", quotient, remainder, n + 1);
        chk("b2b2_quotient", quotient, 32'd19);
        chk("b2b2_remainder", remainder, 32'd1);
        chk("b2b_period", n + 1, LAT + 1);

        // Random identity checks.
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
`ifdef SIGNED_DIV_EN
            a[31] = 1'b0;
            b[31] = 1'b0;
`endif
            if (b == 32'd0) b = 32'd1;
            do_op(a, b, lat, busy0);
            recon = {32'd0, quotient} * {32'd0, b} + {32'd0, remainder};
            checks++;
            if (recon != {32'd0, a} || remainder >= b || lat != LAT) begin
                failures++;
                $display("FAIL random a=%h b=%h quotient=%h remainder=%h lat=%0d expected identity with lat=%0d",
                         a, b, quotient, remainder, lat, LAT);
            end
        end
        $display("random: 300 pairs checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
